ttt_status_tx: RTL
==================

# ttt_status_tx

Board-status serializer for the tic-tac-toe design. It sits downstream of the game controller and upstream of the UART transmitter. On each update request it snapshots the 18-bit board, the current player and the win flag, then streams an ASCII rendering of the board one byte at a time over a valid/ready byte interface to the UART transmit path. Requests that arrive while a frame is in flight are coalesced into exactly one follow-up frame.

## Interface
- EMPTY_CHAR, 8'h2E ('.'): ASCII byte emitted for an empty cell.
- clk  in  1  system clock; one clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- board_state  in  18  cell k at bits [2k+1:2k], k=0..8, row-major, cell 0 top-left; 00 empty, 01 X, 10 O, 11 invalid.
- current_player  in  1  0 = X to move, 1 = O to move.
- win_flag  in  1  game won.
- update  in  1  single-cycle request to send a frame.
- tx_ready  in  1  downstream can accept a byte this cycle.
- tx_valid  out  1  tx_data holds a valid byte.
- tx_data  out  8  byte to transmit.
- busy  out  1  frame in progress.

## Operation
- Frame layout, 18 bytes, index 0..17:
  - Rows 0..2: three cell chars, then 0x0D, 0x0A.
  - Status char, then 0x0D, 0x0A.
- Cell char mapping: 00 -> EMPTY_CHAR, 01 -> 'X' (0x58), 10 -> 'O' (0x4F), 11 -> '?' (0x3F).
- Status char: 'W' (0x57) if the latched win_flag = 1; else 'O' if the latched current_player = 1; else 'X'.
- Snapshot: board_state, current_player and win_flag are registered at frame start. Input changes during a frame do not affect that frame.
- FSM with two states:
  - IDLE -> SEND when update = 1 or pending = 1. In that cycle: latch the snapshot, set idx = 0, clear pending.
  - SEND: on handshake (tx_valid & tx_ready), idx increments. The handshake at idx = last goes to IDLE.
- pending flag:
  - Set by update while in SEND, including the cycle of the last handshake.
  - Any number of updates during one frame produce exactly one extra frame.
  - Cleared when that frame starts.
- tx_data is a registered function of idx and the snapshot. It must not change while tx_valid = 1 and tx_ready = 0.
- tx_valid = 1 throughout SEND. busy = (state == SEND).
- Reset values: tx_valid 0, tx_data 8'h00, busy 0, pending 0, idx 0, state IDLE, snapshot 0.
- Reset asserted mid-frame aborts the frame immediately; the frame is not resumed. The next update starts at byte 0.

## Timing
- update sampled at edge N -> tx_valid = 1 with byte 0 after edge N (visible in cycle N+1).
- With tx_ready held at 1: one byte per cycle, 18 consecutive cycles; tx_valid drops after the last handshake.
- Pending frame: exactly one IDLE cycle (tx_valid = 0) between the last byte of a frame and byte 0 of the next.
- update in the same cycle as the last handshake sets pending; the next frame follows after the one-cycle gap.
- Without backpressure, minimum frame period is 19 cycles.
- Inputs are sampled only at frame start; the upstream controller must hold them stable in the cycle update is asserted.

## Configuration
- TTT_STATUS_HEADER_EN defined:
  - Every frame is prefixed with ANSI cursor-home 0x1B, 0x5B, 0x48.
  - Frame length is 21 bytes (idx 0..20); board bytes shift by 3.
  - Minimum period without backpressure is 22 cycles.
- Undefined: 18-byte frame exactly as described above. The idx counter width is sized to the frame length in both builds.

## Test plan
- Reset, all-empty board, player 0, win 0, update pulse, tx_ready = 1 -> bytes 2E 2E 2E 0D 0A ×3, then 58 0D 0A; 18 consecutive cycles starting the cycle after update; tx_valid = 0 afterwards.
- board_state = 18'b10_01_00_00_11_00_00_00_01, tx_ready toggled every cycle -> row bytes 58 2E 2E / 2E 3F 2E / 2E 58 4F; tx_data stable on every cycle with valid & !ready; exactly 18 handshakes.
- win_flag = 1, current_player = 1 -> status byte 57; win_flag = 0, current_player = 1 -> status byte 4F.
- Three update pulses during a frame while board_state changes mid-frame -> first frame shows the original snapshot; exactly one more frame after a one-cycle gap, showing the board as of its start cycle.
- reset_n pulsed low at byte 7 -> tx_valid and busy go 0 asynchronously; the next update emits byte 0 first.
- Build with TTT_STATUS_HEADER_EN -> first three bytes 1B 5B 48, 21 bytes per frame, status byte at idx 18.

Source files
------------

// File: rtl/ttt_status_tx_if.sv
// Byte stream from the board-status serializer to the UART transmit path.
interface ttt_status_tx_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/ttt_status_tx.sv
// Board-status serializer: snapshots board/player/win on update and streams an ASCII frame, one byte per handshake.
// Define TTT_STATUS_HEADER_EN to prefix every frame with ANSI cursor-home (1B 5B 48), giving 21 bytes instead of 18.
module ttt_status_tx #(
  parameter logic [7:0] EMPTY_CHAR = 8'h2E
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [17:0]            board_state,
  input  logic                   current_player,
  input  logic                   win_flag,
  input  logic                   update,
  output logic                   busy,
  ttt_status_tx_if.master        tx_if
);

`ifdef TTT_STATUS_HEADER_EN
  localparam int HDR_LEN = 3;
`else
  localparam int HDR_LEN = 0;
`endif
  localparam int FRAME_LEN = HDR_LEN + 18;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int LAST      = FRAME_LEN - 1;

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [17:0]        r_board;
  logic               r_player;
  logic               r_win;
  logic [IDX_W-1:0]   r_idx;
  logic               r_pending;
  logic [7:0]         r_tx_data;
  logic               w_hs;
  logic               w_last;
  logic               w_start;
  logic [IDX_W-1:0]   w_idx_nxt;

  function automatic logic [7:0] cell_char(input logic [1:0] c);
    logic [7:0] res;
    case (c)
      2'b00:   res = EMPTY_CHAR;
      2'b01:   res = 8'h58;
      2'b10:   res = 8'h4F;
      default: res = 8'h3F;
    endcase
    return res;
  endfunction

  // Payload position = idx minus header; each board row is 3 cells + CR LF.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx, input logic [17:0] b,
                                            input logic p, input logic w);
    logic [7:0] res;
    int         pos;
    res = 8'h0D;
    pos = int'(idx) - HDR_LEN;
    if (pos < 0) begin
      case (int'(idx))
        0:       res = 8'h1B;
        1:       res = 8'h5B;
        default: res = 8'h48;
      endcase
    end else begin
      case (pos)
        0, 1, 2:     res = cell_char(b[2*pos +: 2]);
        5, 6, 7:     res = cell_char(b[2*(pos-2) +: 2]);
        10, 11, 12:  res = cell_char(b[2*(pos-4) +: 2]);
        15:          res = w ? 8'h57 : (p ? 8'h4F : 8'h58);
        4, 9, 14, 17: res = 8'h0A;
        default:     res = 8'h0D;
      endcase
    end
    return res;
  endfunction

  assign w_hs      = tx_if.tx_valid & tx_if.tx_ready;
  assign w_last    = (r_idx == IDX_W'(LAST));
  assign w_idx_nxt = r_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (update || r_pending) begin
          w_state_nxt = ST_SEND;
          w_start     = 1'b1;
        end
      end
      ST_SEND: begin
        if (w_hs && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Updates landing mid-frame (last handshake included) collapse into one follow-up frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             r_pending <= 1'b0;
    else if (w_start)                         r_pending <= 1'b0;
    else if ((r_state == ST_SEND) && update)  r_pending <= 1'b1;
  end

  // Byte 0 comes from the live inputs, since the snapshot is loaded on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_board   <= 18'd0;
      r_player  <= 1'b0;
      r_win     <= 1'b0;
      r_idx     <= '0;
      r_tx_data <= 8'h00;
    end else if (w_start) begin
      r_board   <= board_state;
      r_player  <= current_player;
      r_win     <= win_flag;
      r_idx     <= '0;
      r_tx_data <= frame_byte({IDX_W{1'b0}}, board_state, current_player, win_flag);
    end else if ((r_state == ST_SEND) && w_hs && !w_last) begin
      r_idx     <= w_idx_nxt;
      r_tx_data <= frame_byte(w_idx_nxt, r_board, r_player, r_win);
    end
  end

  assign tx_if.tx_valid = (r_state == ST_SEND);
  assign tx_if.tx_data  = r_tx_data;
  assign busy           = (r_state == ST_SEND);

endmodule
